seg7_result_scan: RTL and testbench

Downstream display stage for the CPU top level (`main_impl`): consumes the 16-bit `ALU_result` and shows it as four hex digits on the board's multiplexed, active-low seven-segment display. A pending register plus a display register give tear-free updates: new values take effect only at frame boundaries. A hold input freezes the shown value for single-step debugging.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/hex_to_seg7.sv | 15 +
 rtl/seg7_result_scan.sv | 94 +++++++++
 tb/tb_seg7_result_scan.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment displays: hex glyphs (gfedcba, active
// low), the blank pattern and the all-digits-off anode pattern.
package seg7_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned AN_W     = 4;
  localparam int unsigned VALUE_W  = 16;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b0000011;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b1000110;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b0100001;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b0001110;

  // Indexed by nibble value: GLYPH_ROM[4'hA] == GLYPH_A.
  localparam logic [15:0][SEG_W-1:0] GLYPH_ROM = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF    = 4'hF;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-digit decoder.
//   nibble  : 4-bit value 0..F
//   glyph_c : active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    glyph_c
);

  always_comb begin
    glyph_c = GLYPH_ROM[nibble];
  end

endmodule

// File: rtl/seg7_result_scan.sv
// Multiplexed four-digit hex display of the CPU result word with
// frame-synchronous (tear-free) updates and a debug hold.
//   external_clk : system clock (rising edge)
//   reset        : synchronous, active high
//   value        : result word; value_valid strobes a new one
//   hold         : ignore strobes, freeze the shown value, light dp on digit 0
//   an/seg/dp    : registered, active-low digit enables, segments, decimal point
module seg7_result_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic               external_clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  input  logic               hold,
  output logic [AN_W-1:0]    an,
  output logic [SEG_W-1:0]   seg,
  output logic               dp
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]    cnt;
  logic [1:0]          idx;
  logic [VALUE_W-1:0]  pend;
  logic [VALUE_W-1:0]  disp;
  logic                pend_full;

  logic                take_c;
  logic                wrap_c;
  logic                boundary_c;
  logic                blank_c;
  logic [NIBBLE_W-1:0] nibble_c;
  logic [SEG_W-1:0]    glyph_c;

  // Control decode and digit selection for the current idx.
  always_comb begin
    take_c     = value_valid && !hold;
    wrap_c     = (cnt == CNT_MAX);
    boundary_c = wrap_c && (idx == 2'd3);
    nibble_c   = disp[{idx, 2'b00} +: NIBBLE_W];
    // A digit is a leading zero when it and every more significant nibble are 0.
    blank_c    = BLANK_LEADING && (idx != 2'd0) && ((disp >> {idx, 2'b00}) == '0);
  end

  hex_to_seg7 u_dec (
    .nibble  (nibble_c),
    .glyph_c (glyph_c)
  );

  // Refresh counter, capture/display registers and output registers.
  always_ff @(posedge external_clk) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      disp      <= '0;
      an        <= AN_OFF;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
      if (wrap_c) begin
        idx <= idx + 2'd1;
      end

      if (take_c) begin
        pend <= value;
      end

      // A take on the boundary bypasses pend straight into disp.
      if (boundary_c) begin
        pend_full <= 1'b0;
        if (take_c) begin
          disp <= value;
        end else if (pend_full) begin
          disp <= pend;
        end
      end else if (take_c) begin
        pend_full <= 1'b1;
      end

      an  <= ~(AN_W'(1) << idx);
      seg <= blank_c ? SEG_BLANK : glyph_c;
      dp  <= !(hold && (idx == 2'd0));
    end
  end

endmodule

// File: tb/tb_seg7_result_scan.sv
// Bench for seg7_result_scan with REFRESH_DIV=4, BLANK_LEADING=1.
module tb_seg7_result_scan;

  localparam int N     = 4;
  localparam int FRAME = 4 * N;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        value_valid;
  logic        hold;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  seg7_result_scan #(.REFRESH_DIV(N), .BLANK_LEADING(1'b1)) dut (
    .external_clk (clk),
    .reset        (reset),
    .value        (value),
    .value_valid  (value_valid),
    .hold         (hold),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Behavioural model: k is the cycle number since reset release.
  int          k = 0;
  logic [15:0] m_disp, m_pend;
  bit          m_pf;
  bit          model_on = 0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  function automatic logic [6:0] model_seg(logic [15:0] d, int i);
    int upper;
    upper = int'(d) >> (4 * i);
    if (i > 0 && upper == 0) return 7'h7F;
    return glyph_tbl[upper & 15];
  endfunction

  always @(posedge clk) begin
    int  i;
    bit  take, boundary;
    model_on = 1;
    if (reset) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      k = 0; m_disp = '0; m_pend = '0; m_pf = 0;
    end else begin
      i        = (k / N) % 4;
      exp_an   = 4'hF & ~(4'(1) << i);
      exp_seg  = model_seg(m_disp, i);
      exp_dp   = !(hold && i == 0);
      take     = value_valid && !hold;
      boundary = (k % FRAME) == FRAME - 1;
      if (boundary) begin
        if (take) m_disp = value;
        else if (m_pf) m_disp = m_pend;
        m_pf = 0;
      end else if (take) begin
        m_pf = 1;
      end
      if (take) m_pend = value;
      k++;
    end
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      check("model_an",  16'(an),  16'(exp_an));
      check("model_seg", 16'(seg), 16'(exp_seg));
      check("model_dp",  16'(dp),  16'(exp_dp));
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(logic [15:0] v);
    value = v; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_phase(int p);
    bit found = 0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      if (k % FRAME == p) found = 1;
      else @(negedge clk);
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL wait_phase timeout phase=%0d", p);
    end
  endtask

  // Wait (bounded) until digit d is lit, then check its glyph.
  task automatic expect_digit(string name, int d, logic [6:0] g);
    bit         found = 0;
    logic [3:0] want;
    want = 4'hF & ~(4'(1) << d);
    for (int n = 0; n < FRAME + 2 && !found; n++) begin
      @(negedge clk);
      if (an == want) found = 1;
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL %s digit %0d never lit, an=%b", name, d, an);
    end else begin
      check(name, 16'(seg), 16'(g));
    end
  endtask

  initial begin
    reset = 1'b1; value = '0; value_valid = 1'b0; hold = 1'b0;

    // 1. Reset and idle scan
    step(3);
    check("rst_an",  16'(an),  16'h000F);
    check("rst_seg", 16'(seg), 16'h007F);
    check("rst_dp",  16'(dp),  16'h0001);
    reset = 1'b0;
    step(1);
    check("first_an",  16'(an),  16'h000E);
    check("first_seg", 16'(seg), 16'h0040);
    step(4);
    check("idle_an1",  16'(an),  16'h000D);
    check("idle_seg1", 16'(seg), 16'h007F);
    step(4);
    check("idle_an2",  16'(an),  16'h000B);
    step(4);
    check("idle_an3",  16'(an),  16'h0007);
    check("idle_seg3", 16'(seg), 16'h007F);

    // 2. Basic capture mid-frame
    wait_phase(5);
    strobe(16'hA3F0);
    step(2 * FRAME);
    expect_digit("a3f0_d0", 0, 7'b1000000);
    expect_digit("a3f0_d1", 1, 7'b0001110);
    expect_digit("a3f0_d2", 2, 7'b0110000);
    expect_digit("a3f0_d3", 3, 7'b0001000);

    // 3. Leading-zero blanking
    wait_phase(3);
    strobe(16'h0005);
    step(2 * FRAME);
    expect_digit("0005_d0", 0, 7'b0010010);
    expect_digit("0005_d1", 1, 7'h7F);
    expect_digit("0005_d3", 3, 7'h7F);
    wait_phase(3);
    strobe(16'h0100);
    step(2 * FRAME);
    expect_digit("0100_d0", 0, 7'b1000000);
    expect_digit("0100_d1", 1, 7'b1000000);
    expect_digit("0100_d2", 2, 7'b1111001);
    expect_digit("0100_d3", 3, 7'h7F);

    // 4. Overwrite within a frame, then a strobe on the boundary cycle
    wait_phase(2);
    strobe(16'h1111);
    step(2);
    strobe(16'h2222);
    step(2 * FRAME);
    expect_digit("2222_d0", 0, 7'b0100100);
    wait_phase(FRAME - 1);
    value = 16'h3333; value_valid = 1'b1;
    step(1);
    value_valid = 1'b0;
    step(1);
    check("bnd_an",  16'(an),  16'h000E);
    check("bnd_seg", 16'(seg), 16'h0030);

    // 5. Hold freezes the display and drops strobes
    step(3);
    hold = 1'b1;
    strobe(16'hBEEF);
    step(2 * FRAME);
    expect_digit("hold_d0", 0, 7'b0110000);
    check("hold_dp0", 16'(dp), 16'h0000);
    expect_digit("hold_d1", 1, 7'b0110000);
    check("hold_dp1", 16'(dp), 16'h0001);
    hold = 1'b0;
    step(2 * FRAME);
    expect_digit("unhold_d0", 0, 7'b0110000);
    // A value pending before hold rises is still loaded.
    wait_phase(4);
    strobe(16'h4444);
    hold = 1'b1;
    step(2 * FRAME);
    expect_digit("pendhold_d0", 0, 7'b0011001);
    hold = 1'b0;

    // 6. Reset mid-frame with a value pending
    wait_phase(5);
    strobe(16'h7777);
    reset = 1'b1;
    step(1);
    check("mid_rst_an",  16'(an),  16'h000F);
    check("mid_rst_seg", 16'(seg), 16'h007F);
    check("mid_rst_dp",  16'(dp),  16'h0001);
    step(1);
    reset = 1'b0;
    step(1);
    check("post_rst_an",  16'(an),  16'h000E);
    check("post_rst_seg", 16'(seg), 16'h0040);
    step(2 * FRAME);
    expect_digit("post_rst_d0", 0, 7'b1000000);
    expect_digit("post_rst_d3", 3, 7'h7F);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
